// File: rtl/mult_seq_ctrl_if.sv
// Requester-side handshake bundle for mult_seq_ctrl.
//   start   : job request, accepted on a clock edge where start=1 and ready=1
//   A, X    : multiplicand / multiplier, sampled at acceptance
//   ready   : controller idle and able to accept
//   busy    : job in progress (multiplier clear or serial feed)
//   done    : one-cycle pulse, product valid
//   product : exact unsigned A*X, held from done until the next acceptance
// Modports: master = requester (MAC/accumulator control), slave = controller.
interface mult_seq_ctrl_if #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 8
);
  logic           start;
  logic [N-1:0]   A;
  logic [M-1:0]   X;
  logic           ready;
  logic           busy;
  logic           done;
  logic [N+M-1:0] product;

  modport master (
    output start, A, X,
    input  ready, busy, done, product
  );

  modport slave (
    input  start, A, X,
    output ready, busy, done, product
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequencer for a bit-serial multiplier (MULT_full_seq).
// Accepts a parallel multiplicand A and multiplier X, clears the multiplier for one cycle, then
// streams A LSB-first followed by M zero bits into the serial input while collecting the serial
// product bits into an (N+M)-bit result, and finally pulses done.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   req       : requester handshake (mult_seq_ctrl_if.slave)
//   mult_rst  : reset to the multiplier (rst OR clear phase)
//   mult_a    : serial multiplicand bit to the multiplier
//   mult_X    : latched multiplier operand, stable from acceptance to done
//   mult_aX   : serial product bit from the multiplier, LAT cycles behind mult_a
//
// Build option: define MULT_SEQ_CTRL_EARLY_TERM_EN to shorten the feed to the highest set bit
// of A (plus M + LAT), and to skip the feed entirely when A is zero.
module mult_seq_ctrl #(
  parameter int unsigned N   = 8,
  parameter int unsigned M   = 8,
  parameter int unsigned LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  mult_seq_ctrl_if.slave   req,
  output logic             mult_rst,
  output logic             mult_a,
  output logic [M-1:0]     mult_X,
  input  logic             mult_aX
);

  localparam int unsigned L  = N + M + LAT;
  localparam int unsigned PW = N + M;
  localparam int unsigned CW = $clog2(L + 1);

  typedef enum logic [1:0] {StIdle, StClr, StFeed, StDone} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_sh_q, a_sh_d;
  logic [M-1:0]    x_q, x_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   last_cnt;

`ifdef MULT_SEQ_CTRL_EARLY_TERM_EN
  logic [CW-1:0]   last_q, last_d;
  logic [CW-1:0]   top;

  // Index of the highest set bit of A; zero when A is zero (that case skips the feed).
  always_comb begin
    top = '0;
    for (int i = 0; i < N; i++) begin
      if (req.A[i]) top = CW'(i);
    end
  end

  assign last_cnt = last_q;
`else
  assign last_cnt = CW'(L - 1);
`endif

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    x_d     = x_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
`ifdef MULT_SEQ_CTRL_EARLY_TERM_EN
    last_d  = last_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (req.start) begin
          a_sh_d  = req.A;
          x_d     = req.X;
          prod_d  = '0;
          cnt_d   = '0;
`ifdef MULT_SEQ_CTRL_EARLY_TERM_EN
          last_d  = top + CW'(M + LAT);
`endif
          state_d = StClr;
        end
      end
      StClr: begin
`ifdef MULT_SEQ_CTRL_EARLY_TERM_EN
        // a_sh still holds the unshifted A here.
        if (a_sh_q == '0) state_d = StDone;
        else              state_d = StFeed;
`else
        state_d = StFeed;
`endif
      end
      StFeed: begin
        a_sh_d = a_sh_q >> 1;
        // Product bit j arrives LAT cycles after serial bit j was driven.
        for (int i = 0; i < PW; i++) begin
          if ((cnt_q >= CW'(LAT)) && ((cnt_q - CW'(LAT)) == CW'(i))) prod_d[i] = mult_aX;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == last_cnt) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      x_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
`ifdef MULT_SEQ_CTRL_EARLY_TERM_EN
      last_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      x_q     <= x_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
`ifdef MULT_SEQ_CTRL_EARLY_TERM_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    req.ready   = (state_q == StIdle);
    req.busy    = (state_q == StClr) || (state_q == StFeed);
    req.done    = (state_q == StDone);
    req.product = prod_q;
    // Reset input goes straight through so a mid-job reset also clears the multiplier.
    mult_rst    = rst || (state_q == StClr);
    mult_a      = (state_q == StFeed) && (cnt_q < CW'(N)) && a_sh_q[0];
    mult_X      = x_q;
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;
  localparam int unsigned N   = 8;
  localparam int unsigned M   = 8;
  localparam int unsigned LAT = 1;
`ifdef MULT_SEQ_CTRL_EARLY_TERM_EN
  localparam bit Et = 1'b1;
`else
  localparam bit Et = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_seq_ctrl_if #(.N(N), .M(M)) bus ();

  logic         mult_rst;
  logic         mult_a;
  logic [M-1:0] mult_X;
  logic         mult_aX;

  mult_seq_ctrl #(.N(N), .M(M), .LAT(LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.slave),
    .mult_rst(mult_rst),
    .mult_a  (mult_a),
    .mult_X  (mult_X),
    .mult_aX (mult_aX)
  );

  // Serial multiplier model: remembers the bits fed since its last reset and presents bit k-LAT
  // of (fed value * X), where k is the number of bits fed so far.
  logic [63:0] fed_q;
  int unsigned nfed_q;
  logic [63:0] full_prod;

  always @(posedge clk) begin
    if (mult_rst) begin
      fed_q  <= '0;
      nfed_q <= 0;
    end else if (nfed_q < 40) begin
      fed_q  <= fed_q | (64'(mult_a) << nfed_q);
      nfed_q <= nfed_q + 1;
    end
  end

  always_comb begin
    full_prod = fed_q * 64'(mult_X);
    mult_aX   = 1'b0;
    if (nfed_q >= LAT) mult_aX = full_prod[nfed_q - LAT];
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected done cycle counted from the acceptance edge.
  function automatic int exp_lat(input logic [7:0] a);
    int top;
    if (!Et) return N + M + LAT + 2;
    if (a == 0) return 2;
    top = 0;
    for (int i = 0; i < 8; i++) if (a[i]) top = i;
    return top + 1 + M + LAT + 2;
  endfunction

  // Runs one job; poke>0 raises start again (with junk operands) in that cycle while busy.
  task automatic run_job(input logic [7:0] a, input logic [7:0] x, input int exp, input int poke,
                         output logic [15:0] prod, output int lat, output int ndone,
                         output int busy_bad);
    prod = '0; lat = 0; ndone = 0; busy_bad = 0;
    @(negedge clk);
    check("ready_before_start", bus.ready, 1);
    bus.start = 1'b1; bus.A = a; bus.X = x;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = 8'($urandom); bus.X = 8'($urandom);
    for (int c = 1; c <= exp + 2; c++) begin
      if (c > 1) @(negedge clk);
      bus.start = (c == poke);
      if (bus.done) begin
        ndone++;
        if (lat == 0) begin lat = c; prod = bus.product; end
      end
      if (bus.busy !== (c < exp)) busy_bad++;
    end
    bus.start = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  x;
    logic [15:0] prod;
    int          lat_def;
    int          lat_et;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [15:0] prod;
    int lat, ndone, busy_bad, nd, d1, d2, r1, b2;
    logic [15:0] p1, p2;
    logic [7:0] ra, rx;

    vecs[0] = '{8'hFF, 8'hAA, 16'hA956, 19, 19};
    vecs[1] = '{8'h03, 8'hFF, 16'h02FD, 19, 13};
    vecs[2] = '{8'h00, 8'h5A, 16'h0000, 19, 2};
    vecs[3] = '{8'h80, 8'h80, 16'h4000, 19, 19};
    vecs[4] = '{8'h01, 8'hFF, 16'h00FF, 19, 12};

    // Reset state
    rst = 1'b1; bus.start = 1'b0; bus.A = '0; bus.X = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_product", bus.product, 0);
    check("rst_mult_a", mult_a, 0);
    check("rst_mult_X", mult_X, 0);
    check("rst_mult_rst", mult_rst, 1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_mult_rst", mult_rst, 0);
    check("idle_ready", bus.ready, 1);

    // Directed vectors
    foreach (vecs[i]) begin
      int e;
      e = Et ? vecs[i].lat_et : vecs[i].lat_def;
      run_job(vecs[i].a, vecs[i].x, e, 0, prod, lat, ndone, busy_bad);
      check($sformatf("vec%0d_product", i), prod, vecs[i].prod);
      check($sformatf("vec%0d_done_cycle", i), lat, e);
      check($sformatf("vec%0d_done_count", i), ndone, 1);
      check($sformatf("vec%0d_busy_window", i), busy_bad, 0);
      check($sformatf("vec%0d_product_held", i), bus.product, vecs[i].prod);
    end

    // Start during busy is ignored
    run_job(8'hFF, 8'hAA, exp_lat(8'hFF), 5, prod, lat, ndone, busy_bad);
    check("poke_product", prod, 16'hA956);
    check("poke_done_count", ndone, 1);
    check("poke_busy_window", busy_bad, 0);

    // Reset at FEED cycle 6 (cycle 7 after acceptance)
    @(negedge clk);
    bus.start = 1'b1; bus.A = 8'hFF; bus.X = 8'hAA;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_busy_before", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_mult_rst", mult_rst, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ready", bus.ready, 1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_product", bus.product, 0);
    nd = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check("midrst_no_done", nd, 0);
    run_job(8'h81, 8'h81, exp_lat(8'h81), 0, prod, lat, ndone, busy_bad);
    check("after_rst_product", prod, 16'h4101);
    check("after_rst_done_cycle", lat, exp_lat(8'h81));

    // Back-to-back with start held high
    @(negedge clk);
    bus.start = 1'b1; bus.A = 8'hFF; bus.X = 8'hFF;
    d1 = 0; d2 = 0; r1 = 0; b2 = 0; p1 = '0; p2 = '0;
    for (int c = 1; c <= 70 && d2 == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin bus.A = 8'h01; bus.X = 8'h01; end
      if (bus.done) begin
        if (d1 == 0) begin d1 = c; p1 = bus.product; end
        else begin d2 = c; p2 = bus.product; end
      end
      if (d1 > 0 && c == d1 + 1) r1 = bus.ready;
      if (d1 > 0 && c == d1 + 2) begin b2 = bus.busy; bus.start = 1'b0; end
    end
    bus.start = 1'b0;
    check("b2b_first_product", p1, 16'hFE01);
    check("b2b_first_done", d1, exp_lat(8'hFF));
    check("b2b_ready_after_done", r1, 1);
    check("b2b_second_accepted", b2, 1);
    check("b2b_second_product", p2, 16'h0001);
    check("b2b_second_done", d2, d1 + 1 + exp_lat(8'h01));
    repeat (2) @(negedge clk);

    // Randomised jobs against plain arithmetic
    for (int i = 0; i < 24; i++) begin
      ra = (i % 8 == 0) ? 8'h00 : 8'($urandom);
      rx = 8'($urandom);
      run_job(ra, rx, exp_lat(ra), 0, prod, lat, ndone, busy_bad);
      check($sformatf("rnd%0d_product_%0h_x_%0h", i, ra, rx), prod, 16'(ra) * 16'(rx));
      check($sformatf("rnd%0d_done_cycle", i), lat, exp_lat(ra));
      check($sformatf("rnd%0d_done_count", i), ndone, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
